// File: rtl/lut_sched_pkg.sv
// Shared types and defaults for the time-multiplexed LUT layer scheduler.
package lut_sched_pkg;

  localparam int DEF_NUM_NEURONS = 32;
  localparam int DEF_IN_FEATS    = 16;
  localparam int DEF_FANIN       = 4;
  localparam int DEF_BW          = 2;

  localparam logic CFG_TABLE = 1'b0;
  localparam logic CFG_CONN  = 1'b1;

  typedef enum logic [1:0] {IDLE, EVAL, DRAIN, OUT} state_t;

endpackage

// File: rtl/lut_sched_table_ram.sv
// Truth-table store: one write port, one synchronous read port, no reset.
// A read and a write to the same address in one cycle return the old data.
module lut_sched_table_ram #(
  parameter int AW = 13,
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates one LogicNets layer by issuing one neuron per cycle against a shared
// truth-table RAM. Optional perf counters under LUT_SCHED_PERF_CNT_EN.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int IN_FEATS    = DEF_IN_FEATS,
  parameter int FANIN       = DEF_FANIN,
  parameter int BW          = DEF_BW
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [IN_FEATS*BW-1:0]                  in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [NUM_NEURONS*BW-1:0]               out_data,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic                                    cfg_sel,
  input  logic [$clog2(NUM_NEURONS)+FANIN*BW-1:0] cfg_addr,
  input  logic [FANIN*$clog2(IN_FEATS)-1:0]       cfg_data
`ifdef LUT_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                             perf_frames,
  output logic [31:0]                             perf_stall
`endif
);

  localparam int IDX_W  = $clog2(IN_FEATS);
  localparam int NID_W  = $clog2(NUM_NEURONS);
  localparam int ADDR_W = FANIN * BW;
  localparam int CONN_W = FANIN * IDX_W;

  state_t state, state_nxt;
  logic [NID_W-1:0]              idx, cap_idx;
  logic                          issue, rd_vld, accept, cfg_fire;
  logic [IN_FEATS-1:0][BW-1:0]   frame;
  logic [CONN_W-1:0]             conn [NUM_NEURONS];
  logic [CONN_W-1:0]             conn_cur;
  logic [FANIN-1:0][BW-1:0]      lut_addr;
  logic [BW-1:0]                 rd_data;
  logic [NUM_NEURONS-1:0][BW-1:0] out_q;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (in_valid) state_nxt = EVAL;
      end
      EVAL: begin
        issue = 1'b1;
        if (idx == NID_W'(NUM_NEURONS - 1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign cfg_fire = cfg_valid && cfg_ready;

  // Gather the fan-in features of the neuron being issued into the table address.
  assign conn_cur = conn[idx];
  for (genvar k = 0; k < FANIN; k++) begin : g_gather
    assign lut_addr[k] = frame[conn_cur[IDX_W*k +: IDX_W]];
  end

  lut_sched_table_ram #(
    .AW(NID_W + ADDR_W),
    .BW(BW)
  ) u_table (
    .clk  (clk),
    .we   (cfg_fire && cfg_sel == CFG_TABLE),
    .waddr(cfg_addr),
    .wdata(cfg_data[BW-1:0]),
    .raddr({idx, lut_addr}),
    .rdata(rd_data)
  );

  // Connectivity and frame storage carry no reset; contents are defined by writes.
  always_ff @(posedge clk) begin
    if (cfg_fire && cfg_sel == CFG_CONN) conn[cfg_addr[NID_W-1:0]] <= cfg_data;
    if (accept) frame <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cap_idx <= '0;
      rd_vld  <= 1'b0;
      out_q   <= '0;
    end else begin
      state   <= state_nxt;
      rd_vld  <= issue;
      cap_idx <= idx;
      if (accept)     idx <= '0;
      else if (issue) idx <= idx + 1'b1;
      // Read data arrives one cycle after issue; the neuron id travels alongside.
      if (rd_vld) out_q[cap_idx] <= rd_data;
    end
  end

  assign out_data = out_q;

`ifdef LUT_SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_frames <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_valid && out_ready)  perf_frames <= perf_frames + 32'd1;
      if (out_valid && !out_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed bench for lut_layer_scheduler with hand-computed expectations.
// Perf counter checks compile in when LUT_SCHED_PERF_CNT_EN is defined.
module tb_lut_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] out_data;
  logic        cfg_valid = 1'b0, cfg_ready, cfg_sel = 1'b0;
  logic [12:0] cfg_addr = '0;
  logic [15:0] cfg_data = '0;
`ifdef LUT_SCHED_PERF_CNT_EN
  logic [31:0] perf_frames, perf_stall;
  logic [31:0] pf0;
`endif

  int total = 0, bad = 0;
  int cyc = 0;
  int t, busy, acc, outs, n;
  int acc_t[3];
  logic [31:0] fr_id;
  logic [63:0] exp_id, exp2, q;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut_layer_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data)
`ifdef LUT_SCHED_PERF_CNT_EN
    , .perf_frames(perf_frames), .perf_stall(perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg_wr(input logic sel, input logic [12:0] addr, input logic [15:0] data);
    int k;
    cfg_valid = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    k = 0;
    while (!cfg_ready && k < 100) begin step(); k++; end
    if (!cfg_ready) chk("cfg_tmo", {63'd0, cfg_ready}, 64'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  // Returns one cycle after the accept edge; tt is the accept cycle T.
  task automatic send(input logic [31:0] d, output int tt);
    int k;
    in_valid = 1'b1; in_data = d;
    k = 0;
    while (!in_ready && k < 200) begin step(); k++; end
    if (!in_ready) chk("in_tmo", {63'd0, in_ready}, 64'd1);
    tt = cyc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int tt, output logic [63:0] qq);
    int k;
    k = 0;
    while (!out_valid && k < 100) begin step(); k++; end
    chk("latency", 64'(cyc - tt), 64'd34);
    qq = out_data;
  endtask

  task automatic run(input logic [31:0] d, output logic [63:0] qq);
    int tt;
    send(d, tt);
    wait_out(tt, qq);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    for (int f = 0; f < 16; f++) fr_id[2*f +: 2] = 2'(f % 4);
    for (int i = 0; i < 32; i++) exp_id[2*i +: 2] = 2'(i % 4);
    exp2 = exp_id;
    exp2[3:2]   = 2'd3;   // neuron 1 table patched while busy
    exp2[11:10] = 2'd0;   // neuron 5 reference table, lut_addr 0xE4

    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
`ifdef LUT_SCHED_PERF_CNT_EN
    chk("rst_perf_frames", 64'(perf_frames), 64'd0);
    chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif

    // Identity setup: fan-in 0 of neuron n reads feature n%16, table returns lut_addr[1:0].
    for (int i = 0; i < 32; i++) cfg_wr(1'b1, 13'(i), 16'(i % 16));
    for (int i = 0; i < 32; i++)
      for (int a = 0; a < 256; a++) cfg_wr(1'b0, 13'(i * 256 + a), 16'(a % 4));

    // Identity frame with 10 cycles of backpressure.
    send(fr_id, t);
    chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
    wait_out(t, q);
    chk("ident_data", q, exp_id);
    for (int s = 0; s < 10; s++) begin
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_data", out_data, exp_id);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    chk("stall_end_valid", {63'd0, out_valid}, 64'd1);
    step();
    out_ready = 1'b0;
    chk("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
`ifdef LUT_SCHED_PERF_CNT_EN
    chk("perf_stall", 64'(perf_stall), 64'd10);
    chk("perf_frames1", 64'(perf_frames), 64'd1);
`endif

    // Reference pattern on neuron 5: 01 when lut_addr[3:0]==0 and lut_addr!=F0.
    cfg_wr(1'b1, 13'd5, 16'h3210);
    for (int a = 0; a < 256; a++)
      cfg_wr(1'b0, 13'(5 * 256 + a), (a % 16 == 0 && a != 8'hF0) ? 16'd1 : 16'd0);
    run({fr_id[31:8], 8'h00}, q);
    chk("ref_addr00_n5", 64'(q[11:10]), 64'd1);
    chk("ref_addr00_n6", 64'(q[13:12]), 64'd2);
    run({fr_id[31:8], 8'h01}, q);
    chk("ref_addr01_n5", 64'(q[11:10]), 64'd0);
    run({fr_id[31:8], 8'hF0}, q);
    chk("ref_addrF0_n5", 64'(q[11:10]), 64'd0);
    run({fr_id[31:8], 8'h40}, q);
    chk("ref_addr40_n5", 64'(q[11:10]), 64'd1);

    // Config held from T+3: must wait for IDLE and leave the current frame alone.
    send(fr_id, t);
    step(); step();
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_addr = 13'(1 * 256 + 1); cfg_data = 16'd3;
    busy = 0; n = 0;
    while (!out_valid && n < 100) begin
      if (cfg_ready) busy++;
      step(); n++;
    end
    chk("cfg_busy_ready", 64'(busy), 64'd0);
    chk("cfg_busy_latency", 64'(cyc - t), 64'd34);
    chk("cfg_busy_n1", 64'(out_data[3:2]), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("cfg_idle_ready", {63'd0, cfg_ready}, 64'd1);
    step();
    cfg_valid = 1'b0;

    // Reset pulse in cycle T+10.
    send(fr_id, t);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    run(fr_id, q);
    chk("post_rst_data", q, exp2);

    // Three frames back to back with out_ready held high.
`ifdef LUT_SCHED_PERF_CNT_EN
    pf0 = perf_frames;
`endif
    acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = fr_id;
    acc = 0; outs = 0; n = 0;
    while (outs < 3 && n < 300) begin
      if (in_valid && in_ready && acc < 3) begin acc_t[acc] = cyc; acc++; end
      if (out_valid) begin chk("b2b_data", out_data, exp2); outs++; end
      step(); n++;
      if (acc == 3) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_outs", 64'(outs), 64'd3);
    chk("b2b_gap01", 64'(acc_t[1] - acc_t[0]), 64'd35);
    chk("b2b_gap12", 64'(acc_t[2] - acc_t[1]), 64'd35);
`ifdef LUT_SCHED_PERF_CNT_EN
    chk("b2b_perf_frames", 64'(perf_frames - pf0), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lut_layer_scheduler.md
# lut_layer_scheduler

Time-multiplexed evaluator for one LogicNets layer. A single truth-table store replaces per-neuron combinational ROMs (8-bit fan-in address, 2-bit activation). The scheduler accepts an input activation frame and visits neurons 0..NUM_NEURONS-1 in order. For each neuron it gathers the configured fan-in features, reads that neuron's table and packs the results into an output frame. It sits between layer stages of the autoencoder datapath, with valid/ready on both sides and a configuration port for tables and connectivity.

## Interface
- NUM_NEURONS, 32, neurons in the layer (power of two, ≥2)
- IN_FEATS, 16, input features per frame (power of two)
- FANIN, 4, inputs per neuron
- BW, 2, activation bit width (input and output)
- Derived: IDX_W = log2(IN_FEATS); NID_W = log2(NUM_NEURONS); ADDR_W = FANIN*BW (8)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input frame valid
- in_ready  out  1  scheduler can accept a frame
- in_data  in  IN_FEATS*BW  feature f at [BW*f +: BW]
- out_valid  out  1  output frame valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_NEURONS*BW  neuron n at [BW*n +: BW]
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted this cycle
- cfg_sel  in  1  0 = truth table, 1 = connectivity
- cfg_addr  in  NID_W+ADDR_W  table: {neuron, lut_addr}; conn: low NID_W bits = neuron
- cfg_data  in  FANIN*IDX_W  table: low BW bits; conn: fan-in k index at [IDX_W*k +: IDX_W]

## Operation
- States: IDLE, EVAL, DRAIN, OUT.
- IDLE:
  - in_ready=1, cfg_ready=1.
  - in_valid accepted: latch in_data into frame register, neuron counter i=0, go EVAL.
  - cfg_valid write and in_valid accept in the same cycle: both performed.
- EVAL:
  - One neuron issued per cycle.
  - lut_addr[BW*k +: BW] = frame feature conn[i][k].
  - Table read address = {i, lut_addr}; table read is synchronous, 1 cycle.
  - i increments each cycle; after i=NUM_NEURONS-1 is issued, go DRAIN.
- DRAIN: one cycle; last read data captured; go OUT.
- Capture: the read result for neuron i is written to out_data[BW*i +: BW] one cycle after issue.
- OUT:
  - out_valid=1; out_data held stable.
  - On out_ready, go IDLE.
- Config writes:
  - Accepted only in IDLE; cfg_ready=0 in all other states. Requester holds cfg_valid until cfg_ready.
  - A table write takes effect for the next frame.
- Truth tables and connectivity are not reset; their contents are undefined until written.
- Reset mid-frame: return to IDLE immediately; partial frame discarded; out_data cleared.

## Timing
- Reset values:
  - in_ready=1, cfg_ready=1
  - out_valid=0, out_data=0
  - state IDLE, i=0
- Accept edge T:
  - EVAL occupies cycles T+1..T+NUM_NEURONS.
  - DRAIN is cycle T+NUM_NEURONS+1.
  - out_valid is first high in cycle T+NUM_NEURONS+2 (latency NUM_NEURONS+2; 34 for defaults).
- Back-to-back throughput: one frame per NUM_NEURONS+3 cycles with out_ready held high.
- No overlap: in_ready=0 from T+1 until the cycle after the out_valid&out_ready handshake.
- Stall: out_valid stays high with out_data unchanged while out_ready is low.

## Configuration
- LUT_SCHED_PERF_CNT_EN defined:
  - Adds outputs perf_frames (32 bits) and perf_stall (32 bits).
  - perf_frames counts completed output handshakes.
  - perf_stall counts OUT cycles with out_ready=0.
  - Both counters wrap at 2^32 and reset to 0.
- Macro undefined: those ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package lut_sched_pkg holds:
  - state enum (IDLE, EVAL, DRAIN, OUT)
  - default parameter constants
  - cfg_sel encodings CFG_TABLE=0, CFG_CONN=1
- Sub-module lut_sched_table_ram:
  - NUM_NEURONS*2^ADDR_W x BW entries, distributed RAM.
  - One write port, one synchronous read port.
  - Read-during-write to the same address returns old data; unreachable under the IDLE-only write rule.
- Connectivity RAM: small register array inside the top module.

## Test plan
- Identity tables:
  - Stimulus: table[n][a] = a[1:0]; conn[n] = {n%16, 0, 0, 0}; frame with feature f = f%4.
  - Response: out_data neuron n = (n%16)%4; out_valid exactly at T+34.
- Reference-pattern table:
  - Stimulus: neuron 5 returns 2'b01 when lut_addr[3:0]=0 and lut_addr≠8'hF0, else 2'b00; conn[5] = {3, 2, 1, 0}.
  - Features 0..3 = {0,0,0,0}: neuron 5 = 01. Features = {0,0,0,1}: neuron 5 = 00.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles after out_valid.
  - Response: out_data stable; in_ready=0 throughout; perf_stall=10 when LUT_SCHED_PERF_CNT_EN is defined.
- Config during busy:
  - Stimulus: cfg_valid held from T+3.
  - Response: cfg_ready=0 until IDLE; write lands in the first IDLE cycle; current frame unaffected.
- Reset mid-frame:
  - Stimulus: rst_n low at T+10 for 1 cycle.
  - Response: next cycle in_ready=1, out_valid=0, out_data=0; a following frame produces correct results.
- Back-to-back:
  - Stimulus: 3 frames, out_ready tied high.
  - Response: accepts spaced 35 cycles apart; perf_frames=3.
